// File: rtl/rf_wb_scheduler_pkg.sv
// Shared register-file definitions used by the writeback scheduler and its arbiter.
package rf_wb_scheduler_pkg;

  localparam int unsigned XLEN          = 32;
  localparam int unsigned RF_ADDR_WIDTH = 5;
  localparam int unsigned REG_NUM       = 32'(1) << RF_ADDR_WIDTH;

  localparam logic [RF_ADDR_WIDTH-1:0] X0       = '0;
  localparam logic [XLEN-1:0]          ZEROWORD = '0;
  localparam logic                     ENABLE   = 1'b1;

endpackage

// File: rtl/rf_wb_scheduler_rr_arbiter.sv
// Round-robin arbiter: one-hot combinational grant, pointer advances past the winner.
module rf_wb_scheduler_rr_arbiter #(
  parameter int unsigned NUM_SRC = 3,
  localparam int unsigned PW = $clog2(NUM_SRC)
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic [NUM_SRC-1:0] req,
  output logic [NUM_SRC-1:0] gnt_c
);

  logic [PW-1:0] r_ptr;
  logic [PW-1:0] w_idx;
  logic [PW-1:0] w_probe;
  logic          w_any;

  // First requester at or after the pointer, wrapping modulo NUM_SRC.
  always_comb begin
    gnt_c   = '0;
    w_idx   = r_ptr;
    w_probe = '0;
    w_any   = 1'b0;
    for (int k = 0; k < int'(NUM_SRC); k++) begin
      w_probe = PW'((int'(r_ptr) + k) % int'(NUM_SRC));
      if (!w_any && req[w_probe]) begin
        gnt_c[w_probe] = 1'b1;
        w_idx          = w_probe;
        w_any          = 1'b1;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_ptr <= '0;
    end else if (w_any) begin
      r_ptr <= (32'(w_idx) == NUM_SRC - 1) ? '0 : PW'(32'(w_idx) + 32'd1);
    end
  end

endmodule

// File: rtl/rf_wb_scheduler.sv
// Register-file write-port owner: arbitrates writeback sources onto one registered
// write stage and keeps the per-GPR busy scoreboard used by decode for hazard checks.
module rf_wb_scheduler #(
  parameter int unsigned XLEN          = rf_wb_scheduler_pkg::XLEN,
  parameter int unsigned RF_ADDR_WIDTH = rf_wb_scheduler_pkg::RF_ADDR_WIDTH,
  parameter int unsigned NUM_SRC       = 3
) (
  input  logic                             clk,
  input  logic                             rst_n,
  input  logic [NUM_SRC-1:0]               wb_valid,
  output logic [NUM_SRC-1:0]               wb_ready,
  input  logic [NUM_SRC*RF_ADDR_WIDTH-1:0] wb_addr,
  input  logic [NUM_SRC*XLEN-1:0]          wb_data,
  output logic                             rf_wen,
  output logic [RF_ADDR_WIDTH-1:0]         rf_waddr,
  output logic [XLEN-1:0]                  rf_wdata,
  input  logic                             iss_valid,
  input  logic [RF_ADDR_WIDTH-1:0]         iss_rd,
  output logic                             iss_ready,
  input  logic [RF_ADDR_WIDTH-1:0]         chk_rs1,
  input  logic [RF_ADDR_WIDTH-1:0]         chk_rs2,
  output logic                             rs1_busy,
  output logic                             rs2_busy,
  output logic                             sb_err
);

  import rf_wb_scheduler_pkg::*;

  localparam int unsigned AW = RF_ADDR_WIDTH;

  logic [NUM_SRC-1:0] w_req;
  logic [NUM_SRC-1:0] w_gnt;
  logic               w_xfer;
  logic [AW-1:0]      w_sel_addr;
  logic [XLEN-1:0]    w_sel_data;
  logic               w_set;

  logic               r_wen;
  logic [AW-1:0]      r_waddr;
  logic [XLEN-1:0]    r_wdata;
  logic [REG_NUM-1:0] r_busy;
  logic               r_sb_err;

  // No grants while reset is asserted so in-flight handshakes are dropped.
  assign w_req = wb_valid & {NUM_SRC{rst_n}};

  rf_wb_scheduler_rr_arbiter #(
    .NUM_SRC (NUM_SRC)
  ) u_arb (
    .clk   (clk),
    .rst_n (rst_n),
    .req   (w_req),
    .gnt_c (w_gnt)
  );

  assign wb_ready = w_gnt;
  assign w_xfer   = |w_gnt;

  always_comb begin
    w_sel_addr = '0;
    w_sel_data = '0;
    for (int i = 0; i < int'(NUM_SRC); i++) begin
      if (w_gnt[i]) begin
        w_sel_addr = wb_addr[i*AW +: AW];
        w_sel_data = wb_data[i*XLEN +: XLEN];
      end
    end
  end

  // Writes to x0 are consumed but never reach the regfile.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_wen   <= 1'b0;
      r_waddr <= X0;
      r_wdata <= XLEN'(ZEROWORD);
    end else begin
      r_wen <= w_xfer && (w_sel_addr != X0) ? ENABLE : 1'b0;
      if (w_xfer) begin
        r_waddr <= w_sel_addr;
        r_wdata <= w_sel_data;
      end
    end
  end

  // A register being written this cycle is already free for issue and operand reads.
  assign iss_ready = (iss_rd == X0) | ~r_busy[iss_rd] | (r_wen & (r_waddr == iss_rd));
  assign rs1_busy  = (chk_rs1 != X0) & r_busy[chk_rs1] & ~(r_wen & (r_waddr == chk_rs1));
  assign rs2_busy  = (chk_rs2 != X0) & r_busy[chk_rs2] & ~(r_wen & (r_waddr == chk_rs2));
  assign w_set     = iss_valid & iss_ready & (iss_rd != X0);

  // Set is applied after clear so a same-cycle issue to the written register wins.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_busy   <= '0;
      r_sb_err <= 1'b0;
    end else begin
      if (r_wen) begin
        r_busy[r_waddr] <= 1'b0;
      end
      if (w_set) begin
        r_busy[iss_rd] <= 1'b1;
      end
      r_busy[0] <= 1'b0;
      if (r_wen && !r_busy[r_waddr] && (r_waddr != X0)) begin
        r_sb_err <= 1'b1;
      end
    end
  end

  assign rf_wen   = r_wen;
  assign rf_waddr = r_waddr;
  assign rf_wdata = r_wdata;
  assign sb_err   = r_sb_err;

endmodule

// File: tb/tb_rf_wb_scheduler.sv
// Self-checking bench for rf_wb_scheduler: directed hazard/reset sequences plus a
// round-robin vector table, with expected RF writes queued and checked one cycle later.
module tb_rf_wb_scheduler;

  localparam int unsigned NS = 3;
  localparam int unsigned AW = 5;
  localparam int unsigned DW = 32;

  logic              clk = 1'b0;
  logic              rst_n;
  logic [NS-1:0]     wb_valid;
  logic [NS-1:0]     wb_ready;
  logic [NS*AW-1:0]  wb_addr;
  logic [NS*DW-1:0]  wb_data;
  logic              rf_wen;
  logic [AW-1:0]     rf_waddr;
  logic [DW-1:0]     rf_wdata;
  logic              iss_valid;
  logic [AW-1:0]     iss_rd;
  logic              iss_ready;
  logic [AW-1:0]     chk_rs1;
  logic [AW-1:0]     chk_rs2;
  logic              rs1_busy;
  logic              rs2_busy;
  logic              sb_err;

  always #5 clk = ~clk;

  rf_wb_scheduler #(
    .XLEN          (DW),
    .RF_ADDR_WIDTH (AW),
    .NUM_SRC       (NS)
  ) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .wb_valid  (wb_valid),
    .wb_ready  (wb_ready),
    .wb_addr   (wb_addr),
    .wb_data   (wb_data),
    .rf_wen    (rf_wen),
    .rf_waddr  (rf_waddr),
    .rf_wdata  (rf_wdata),
    .iss_valid (iss_valid),
    .iss_rd    (iss_rd),
    .iss_ready (iss_ready),
    .chk_rs1   (chk_rs1),
    .chk_rs2   (chk_rs2),
    .rs1_busy  (rs1_busy),
    .rs2_busy  (rs2_busy),
    .sb_err    (sb_err)
  );

  typedef struct {
    logic            wen;
    logic [AW-1:0]   addr;
    logic [DW-1:0]   data;
  } exp_t;

  typedef struct {
    logic [NS-1:0] valid;
    logic [NS-1:0] ready;
  } vec_t;

  exp_t sb_q[$];
  vec_t vecs[12];
  int   n_checks = 0;
  int   n_errors = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
    n_checks++;
    if (act !== req) begin
      n_errors++;
      $display("FAIL %s actual=0x%0h required=0x%0h", name, act, req);
    end
  endtask

  task automatic push_exp(input logic wen, input logic [AW-1:0] addr, input logic [DW-1:0] data);
    exp_t e;
    e.wen  = wen;
    e.addr = addr;
    e.data = data;
    sb_q.push_back(e);
  endtask

  // Advance one cycle and compare the RF write stage against the oldest expectation.
  task automatic clk_step();
    exp_t e;
    @(posedge clk);
    #1;
    if (sb_q.size() > 0) begin
      e = sb_q.pop_front();
      chk("rf_wen", 32'(rf_wen), 32'(e.wen));
      if (e.wen) begin
        chk("rf_waddr", 32'(rf_waddr), 32'(e.addr));
        chk("rf_wdata", rf_wdata, e.data);
      end
    end
  endtask

  task automatic set_src(input int i, input logic [AW-1:0] a, input logic [DW-1:0] d);
    wb_addr[i*AW +: AW] = a;
    wb_data[i*DW +: DW] = d;
  endtask

  initial begin
    exp_t e;
    logic [DW-1:0] d;

    // Round-robin vectors, starting from rr_ptr=1.
    vecs[0]  = '{3'b111, 3'b010};
    vecs[1]  = '{3'b111, 3'b100};
    vecs[2]  = '{3'b111, 3'b001};
    vecs[3]  = '{3'b111, 3'b010};
    vecs[4]  = '{3'b101, 3'b100};
    vecs[5]  = '{3'b101, 3'b001};
    vecs[6]  = '{3'b011, 3'b010};
    vecs[7]  = '{3'b011, 3'b001};
    vecs[8]  = '{3'b000, 3'b000};
    vecs[9]  = '{3'b001, 3'b001};
    vecs[10] = '{3'b110, 3'b010};
    vecs[11] = '{3'b110, 3'b100};

    rst_n     = 1'b0;
    wb_valid  = '0;
    wb_addr   = '0;
    wb_data   = '0;
    iss_valid = 1'b0;
    iss_rd    = '0;
    chk_rs1   = '0;
    chk_rs2   = '0;

    repeat (3) @(posedge clk);
    #1;
    wb_valid = 3'b111;
    #1;
    chk("reset_wb_ready", 32'(wb_ready), 32'h0);
    chk("reset_rf_wen", 32'(rf_wen), 32'h0);
    chk("reset_rf_waddr", 32'(rf_waddr), 32'h0);
    chk("reset_rf_wdata", rf_wdata, 32'h0);
    chk("reset_sb_err", 32'(sb_err), 32'h0);

    wb_valid = '0;
    rst_n    = 1'b1;
    clk_step();
    chk("idle_rf_wen", 32'(rf_wen), 32'h0);
    chk("idle_wb_ready", 32'(wb_ready), 32'h0);
    for (int r = 0; r < 32; r += 5) begin
      iss_rd  = AW'(r);
      chk_rs1 = AW'(r);
      chk_rs2 = AW'(31 - r);
      #1;
      chk($sformatf("idle_iss_ready[%0d]", r), 32'(iss_ready), 32'h1);
      chk($sformatf("idle_rs1_busy[%0d]", r), 32'(rs1_busy), 32'h0);
      chk($sformatf("idle_rs2_busy[%0d]", r), 32'(rs2_busy), 32'h0);
    end
    chk_rs2 = '0;

    // Issue x5, observe RAW/WAW stall, then write it back from src1.
    iss_valid = 1'b1;
    iss_rd    = 5'd5;
    #1;
    chk("x5_issue_ready", 32'(iss_ready), 32'h1);
    clk_step();
    iss_valid = 1'b0;
    chk_rs1   = 5'd5;
    #1;
    chk("x5_rs1_busy", 32'(rs1_busy), 32'h1);
    chk("x5_waw_stall", 32'(iss_ready), 32'h0);
    chk("x5_rs2_free", 32'(rs2_busy), 32'h0);
    wb_valid = 3'b010;
    set_src(1, 5'd5, 32'hDEAD_BEEF);
    #1;
    chk("x5_wb_ready", 32'(wb_ready), 32'h2);
    push_exp(1'b1, 5'd5, 32'hDEAD_BEEF);
    clk_step();
    wb_valid = '0;
    #1;
    chk("x5_bypass_rs1", 32'(rs1_busy), 32'h0);
    chk("x5_bypass_iss", 32'(iss_ready), 32'h1);
    push_exp(1'b0, '0, '0);
    clk_step();
    chk("x5_cleared_rs1", 32'(rs1_busy), 32'h0);
    chk("x5_cleared_iss", 32'(iss_ready), 32'h1);

    // x7: issue during the cycle it is being written, set must win over clear.
    iss_valid = 1'b1;
    iss_rd    = 5'd7;
    #1;
    clk_step();
    iss_valid = 1'b0;
    wb_valid  = 3'b001;
    set_src(0, 5'd7, 32'h7777_7777);
    #1;
    chk("x7_wb_ready", 32'(wb_ready), 32'h1);
    push_exp(1'b1, 5'd7, 32'h7777_7777);
    clk_step();
    wb_valid  = '0;
    iss_valid = 1'b1;
    iss_rd    = 5'd7;
    chk_rs1   = 5'd7;
    #1;
    chk("x7_same_cycle_iss", 32'(iss_ready), 32'h1);
    chk("x7_same_cycle_rs1", 32'(rs1_busy), 32'h0);
    push_exp(1'b0, '0, '0);
    clk_step();
    iss_valid = 1'b0;
    #1;
    chk("x7_busy_after", 32'(rs1_busy), 32'h1);
    chk("x7_waw_after", 32'(iss_ready), 32'h0);

    // Write to x0 is accepted but suppressed.
    wb_valid = 3'b100;
    set_src(2, 5'd0, 32'h0000_1234);
    #1;
    chk("x0_wb_ready", 32'(wb_ready), 32'h4);
    push_exp(1'b0, '0, '0);
    clk_step();
    wb_valid = '0;
    clk_step();
    chk("x0_sb_err", 32'(sb_err), 32'h0);

    // Write to idle x9 raises the sticky scoreboard error.
    wb_valid = 3'b001;
    set_src(0, 5'd9, 32'h0000_0099);
    #1;
    chk("x9_wb_ready", 32'(wb_ready), 32'h1);
    push_exp(1'b1, 5'd9, 32'h0000_0099);
    clk_step();
    wb_valid = '0;
    chk("x9_sb_err_pre", 32'(sb_err), 32'h0);
    push_exp(1'b0, '0, '0);
    clk_step();
    chk("x9_sb_err_set", 32'(sb_err), 32'h1);

    // Round-robin table.
    for (int v = 0; v < 12; v++) begin
      wb_valid = vecs[v].valid;
      for (int i = 0; i < int'(NS); i++) begin
        set_src(i, AW'(i + 1), 32'hA000_0000 | 32'(v << 8) | 32'(i));
      end
      #1;
      chk($sformatf("rr_ready[%0d]", v), 32'(wb_ready), 32'(vecs[v].ready));
      e.wen  = 1'b0;
      e.addr = '0;
      e.data = '0;
      for (int i = 0; i < int'(NS); i++) begin
        if (vecs[v].ready[i]) begin
          e.wen  = 1'b1;
          e.addr = AW'(i + 1);
          e.data = 32'hA000_0000 | 32'(v << 8) | 32'(i);
        end
      end
      sb_q.push_back(e);
      clk_step();
    end
    wb_valid = '0;
    push_exp(1'b0, '0, '0);
    clk_step();
    chk("rr_sb_err_sticky", 32'(sb_err), 32'h1);

    // Reset while x4 busy and src2 pending; rr_ptr moved to 2 beforehand.
    iss_valid = 1'b1;
    iss_rd    = 5'd4;
    wb_valid  = 3'b010;
    set_src(1, 5'd1, 32'h0000_0011);
    #1;
    chk("rst_pre_wb_ready", 32'(wb_ready), 32'h2);
    push_exp(1'b1, 5'd1, 32'h0000_0011);
    clk_step();
    iss_valid = 1'b0;
    chk_rs1   = 5'd4;
    rst_n     = 1'b0;
    wb_valid  = 3'b100;
    set_src(2, 5'd4, 32'h0000_0044);
    #1;
    chk("rst_wb_ready", 32'(wb_ready), 32'h0);
    clk_step();
    chk("rst_rf_wen", 32'(rf_wen), 32'h0);
    chk("rst_rs1_busy", 32'(rs1_busy), 32'h0);
    chk("rst_sb_err", 32'(sb_err), 32'h0);
    iss_rd = 5'd7;
    #1;
    chk("rst_x7_free", 32'(iss_ready), 32'h1);
    rst_n    = 1'b1;
    wb_valid = 3'b110;
    set_src(1, 5'd6, 32'h0000_0066);
    #1;
    chk("rst_first_grant", 32'(wb_ready), 32'h2);
    d = 32'h0000_0066;
    push_exp(1'b1, 5'd6, d);
    clk_step();
    wb_valid = '0;
    push_exp(1'b0, '0, '0);
    clk_step();

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule
